seg_scan_mux: RTL and testbench
===============================

Name: seg_scan_mux

Overview:
- Time-multiplexing scanner that sits directly upstream of the hex-to-7-segment decoder.
- Holds a captured 32-bit display word and rotates through 8 digits at a divided refresh rate.
- Drives active-low anode enables, the 4-bit nibble for the active digit (HexVal, consumed by the decoder), and the active-low decimal point.
- Inserts one clock of all-anodes-off dead time at every digit change to suppress ghosting.

Parameters:
- REFRESH_DIV, 100000: clocks per digit slot; legal range 2..2^20. At 100 MHz this gives 1 kHz per digit.
- NUM_DIGITS, 8: digits scanned. Fixed at 8 for this revision; data width is 4*NUM_DIGITS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- data  input  32  display word; nibble k (bits 4k+3:4k) is shown on digit k.
- load  input  1  single-cycle strobe; captures data and dp_in into shadow registers.
- dp_in  input  8  decimal point request per digit, active-high.
- en  input  1  display enable. When low, all anodes are off; counters keep running.
- An  output  8  anode enables, active-low, one-hot-low when lit.
- HexVal  output  4  nibble for the lit digit, to the decoder.
- dp  output  1  decimal point, active-low.

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - div_cnt=0, digit_sel=0, dead=0
  - shadow_data=0, shadow_dp=0
  - An=8'hFF, HexVal=4'h0, dp=1
- Divider: div_cnt counts 0..REFRESH_DIV-1 and wraps to 0. tick is asserted combinationally when div_cnt==REFRESH_DIV-1.
- On tick:
  - digit_sel increments, wrapping from 7 to 0.
  - dead is set to 1 for exactly the next cycle.
- Output registers update every clock, so there is one cycle of latency from digit_sel/shadow to the pins:
  - If dead or !en: An=8'hFF and dp=1. HexVal still follows digit_sel.
  - Otherwise:
    - An = ~(8'b1 << digit_sel)
    - HexVal = shadow_data[4*digit_sel +: 4]
    - dp = ~shadow_dp[digit_sel]
- Load: on the edge where load=1, the shadow registers take data/dp_in. The new nibble appears on HexVal one edge later. No mid-slot tearing beyond that single-cycle boundary.
- Simultaneous load and tick: both take effect. The next slot shows the new data for the new digit.
- en deassert/assert takes effect on the next output edge; digit rotation is not reset.
- Reset mid-scan returns to digit 0 with all anodes off. The first lit digit appears REFRESH_DIV+2 cycles after reset release (one full slot, then the dead cycle, then the output register).
- Full scan period is 8*REFRESH_DIV clocks. Each digit is lit for REFRESH_DIV-1 clocks per slot.

Optional Feature:
- Macro: SEG_SCAN_LEADING_ZERO_BLANK_EN.
- Defined:
  - Any digit k>0 whose nibble and all higher nibbles are zero and whose shadow_dp[k]=0 is blanked (An=8'hFF, dp=1) during its slot.
  - Digit 0 is never blanked, so an all-zero word shows "0".
  - The blank mask is computed from the shadow registers and registered with the same latency as An.
- Undefined: all 8 digits are always lit as described above. No extra logic is instantiated.

Decomposition:
- Shared package seg_scan_pkg holds:
  - NUM_DIGITS=8, ANODE_OFF=8'hFF, DP_OFF=1'b1, DIGIT_W=3, NIB_W=4
- One natural sub-module: scan_tick_gen (parameter REFRESH_DIV; ports clk, rst, tick), holding the divider counter.
- Digit ring, shadow registers, dead-time logic and output registers stay in seg_scan_mux.

Test Plan:
All scenarios use REFRESH_DIV=4.
- Reset, then release:
  - An=8'hFF and dp=1 for the first 6 cycles.
  - Then An=8'hFE with HexVal=0.
- Load data=32'h89AB_CDEF with dp_in=8'h00 and en=1, observe one full scan:
  - Digit order FE,FD,FB,F7,EF,DF,BF,7F.
  - HexVal sequence F,E,D,C,B,A,9,8.
  - Each lit for 3 clocks and separated by one cycle of An=FF.
- dp_in=8'h05 loaded: dp=0 only while An=FE or FB; dp=1 elsewhere.
- Load 32'h0000_0001 on the same edge as a tick:
  - The following slot shows the new nibble.
  - With SEG_SCAN_LEADING_ZERO_BLANK_EN, digits 1-7 stay FF and only digit 0 lights with HexVal=1.
- Drop en for 10 cycles mid-scan:
  - An=FF throughout.
  - After re-enable, the digit index equals where free-running rotation would be.
- Assert rst for 1 cycle while digit 5 is lit:
  - An=FF immediately (asynchronous).
  - Scan restarts at digit 0.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants and helpers for the 8-digit scanner.
// Optional feature macro: SEG_SCAN_LEADING_ZERO_BLANK_EN.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 3;
  localparam int NIB_W      = 4;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;
  localparam logic                  DP_OFF    = 1'b1;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  // Bit k set: digit k is a leading zero with no dp request.
  function automatic logic [NUM_DIGITS-1:0] lz_blank(
    input logic [NIB_W*NUM_DIGITS-1:0] d,
    input logic [NUM_DIGITS-1:0]       p
  );
    logic zero_above;
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int k = NUM_DIGITS-1; k >= 1; k--) begin
      zero_above  = zero_above && (d[NIB_W*k +: NIB_W] == '0);
      lz_blank[k] = zero_above && !p[k];
    end
  endfunction
`endif

endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if: display word / control in, anode / nibble / dp out.
// The scanner is the slave; the word source is the master.
interface seg_scan_if;
  import seg_scan_pkg::*;

  logic [NIB_W*NUM_DIGITS-1:0] data;
  logic                        load;
  logic [NUM_DIGITS-1:0]       dp_in;
  logic                        en;
  logic [NUM_DIGITS-1:0]       An;
  logic [NIB_W-1:0]            HexVal;
  logic                        dp;

  modport master (
    output data, load, dp_in, en,
    input  An, HexVal, dp
  );

  modport slave (
    input  data, load, dp_in, en,
    output An, HexVal, dp
  );

endinterface

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: refresh divider, one-cycle tick every REFRESH_DIV clocks.
// Range of REFRESH_DIV is 2..2^20.
module scan_tick_gen #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] div_cnt;

  assign tick = (div_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: 8-digit time-multiplexed scanner with dead time per slot.
// Build with SEG_SCAN_LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input logic     clk,
  input logic     rst,
  seg_scan_if.slave bus
);

  logic                        tick;
  logic [DIGIT_W-1:0]          digit_sel;
  logic                        dead;
  logic                        primed;
  logic [NIB_W*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]       shadow_dp;
  logic [NUM_DIGITS-1:0]       blank;
  logic [NUM_DIGITS-1:0]       an_nxt;
  logic [NIB_W-1:0]            hex_nxt;
  logic                        dp_nxt;
  logic                        lit;

  scan_tick_gen #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // First slot after reset is a warm-up: digit 0 lights after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_sel   <= '0;
      dead        <= 1'b0;
      primed      <= 1'b0;
      shadow_data <= '0;
      shadow_dp   <= '0;
    end else begin
      dead <= tick;
      if (tick) begin
        primed <= 1'b1;
        if (primed) digit_sel <= digit_sel + 1'b1;
      end
      if (bus.load) begin
        shadow_data <= bus.data;
        shadow_dp   <= bus.dp_in;
      end
    end
  end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  assign blank = lz_blank(shadow_data, shadow_dp);
`else
  assign blank = '0;
`endif

  always_comb begin
    hex_nxt = shadow_data[NIB_W*digit_sel +: NIB_W];
    lit     = primed && !dead && bus.en && !blank[digit_sel];
    an_nxt  = ANODE_OFF;
    dp_nxt  = DP_OFF;
    if (lit) begin
      an_nxt = ~(8'b1 << digit_sel);
      dp_nxt = ~shadow_dp[digit_sel];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.An     <= ANODE_OFF;
      bus.HexVal <= '0;
      bus.dp     <= DP_OFF;
    end else begin
      bus.An     <= an_nxt;
      bus.HexVal <= hex_nxt;
      bus.dp     <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: scoreboard bench, REFRESH_DIV=4.
// Expected pins come from a slot/phase formula over edges since reset.
module tb_seg_scan_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   n = 0;

  logic [31:0] sd = '0;
  logic [7:0]  sp = '0;
  logic [31:0] cur_d = '0;
  logic [7:0]  cur_p = '0;
  logic        cur_en = 1'b1;
  logic [12:0] exp_q[$];

  seg_scan_if bus ();

  seg_scan_mux #(
    .REFRESH_DIV(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%h want=%h",
               tag, n, got, exp);
    end
  endtask

  function automatic logic is_blank(input int idx,
                                    input logic [31:0] d,
                                    input logic [7:0] p);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    logic [31:0] hi;
    hi = d >> (4 * idx);
    return (idx > 0) && (hi == 0) && !p[idx];
`else
    return 1'b0;
`endif
  endfunction

  // Pins after edge e, given shadows and en before that edge.
  function automatic logic [12:0] model(input int e,
                                        input logic en,
                                        input logic [31:0] d,
                                        input logic [7:0] p);
    int         h;
    logic       lit;
    logic [7:0] an;
    logic       dpo;
    h   = (e < 5) ? 0 : ((e - 5) / 4) % 8;
    lit = (e >= 6) && (((e - 6) % 4) < 3) && en
          && !is_blank(h, d, p);
    an  = 8'hFF;
    dpo = 1'b1;
    if (lit) begin
      an  = ~(8'h01 << h);
      dpo = ~p[h];
    end
    return {an, d[4*h +: 4], dpo};
  endfunction

  task automatic cyc(input logic ld);
    logic [12:0] e;
    bus.load  = ld;
    bus.data  = cur_d;
    bus.dp_in = cur_p;
    bus.en    = cur_en;
    exp_q.push_back(model(n + 1, cur_en, sd, sp));
    if (ld) begin
      sd = cur_d;
      sp = cur_p;
    end
    @(posedge clk);
    n++;
    #1;
    if (exp_q.size() == 0) begin
      chk("queue", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("An", bus.An, e[12:5]);
      chk("HexVal", bus.HexVal, e[4:1]);
      chk("dp", bus.dp, e[0]);
    end
    bus.load = 1'b0;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0);
  endtask

  task automatic load_word(input logic [31:0] d,
                           input logic [7:0] p);
    cur_d = d;
    cur_p = p;
    cyc(1'b1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_An"}, bus.An, 8'hFF);
    chk({tag, "_Hex"}, bus.HexVal, 4'h0);
    chk({tag, "_dp"}, bus.dp, 1'b1);
  endtask

  initial begin
    bus.load  = 1'b0;
    bus.data  = '0;
    bus.dp_in = '0;
    bus.en    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    n = 0;

    run(12);

    load_word(32'h89AB_CDEF, 8'h00);
    run(40);

    load_word(32'h89AB_CDEF, 8'h05);
    run(34);

    // Load on a tick edge: edges with n%4==0 carry the tick.
    while (((n + 1) % 4) != 0) cyc(1'b0);
    load_word(32'h0000_0001, 8'h00);
    run(34);

    load_word(32'h89AB_CDEF, 8'h81);
    run(6);
    cur_en = 1'b0;
    run(10);
    cur_en = 1'b1;
    run(20);

    // Async reset while digit 5 is lit.
    while (!((n >= 6) && (((n - 6) / 4) % 8 == 5)
             && (((n - 6) % 4) == 1))) cyc(1'b0);
    #2 rst = 1'b1;
    #1;
    check_idle("async_rst");
    exp_q.delete();
    @(posedge clk);
    #1;
    check_idle("rst_hold");
    rst = 1'b0;
    n = 0;
    sd = '0;
    sp = '0;
    run(14);

    load_word(32'h1234_5678, 8'hF0);
    run(36);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
